cp0_exception_unit: RTL
=======================

# cp0_exception_unit

Coprocessor-0 block for the pipelined MIPS core: holds SR, Cause, EPC and PRId, samples the hardware interrupt lines driven by the timers and other bus devices, and decides each cycle whether the pipeline must take an interrupt or exception. It sits downstream of the timer IRQ outputs and beside the M stage. It consumes `mfc0`/`mtc0`/`eret` traffic and the per-instruction exception code, and produces the flush/redirect request plus EPC for the PC unit.

## Interface
- `PRID`, 32'h4D49_5053, constant value returned for register 15.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low. Clears all state when low.
- `A1` input 5: read register number for `mfc0`.
- `A2` input 5: write register number for `mtc0`.
- `DIn` input 32: `mtc0` write data.
- `We` input 1: `mtc0` write enable, M stage.
- `PC` input 32: address of the M-stage instruction.
- `BD` input 1: the M-stage instruction sits in a delay slot.
- `ExcCode` input 5: synchronous exception code of the M-stage instruction; 0 means none.
- `HWInt` input 6: level interrupt lines; bit 0 is timer 0, bit 1 is timer 1.
- `EXLClr` input 1: `eret` in the M stage.
- `Req` output 1: take exception/interrupt this cycle (flush and redirect).
- `EPC` output 32: current EPC register, used as the `eret` target.
- `DOut` output 32: `mfc0` read data.

## Operation
- **SR (reg 12):** IM = bits 15:10, EXL = bit 1, IE = bit 0. All other bits read 0 and ignore writes.
- **Cause (reg 13):** BD = bit 31, IP = bits 15:10, ExcCode = bits 6:2. All other bits read 0. Cause is read-only to `mtc0`.
- **EPC (reg 14):** 32 bits. An `mtc0` write stores `{DIn[31:2],2'b00}`.
- **PRId (reg 15):** reads as `PRID`; writes are ignored.
- **Other register numbers:** read 0; writes are ignored.
- **Pending interrupt:** IntPend = |(HWInt & IM) & IE & !EXL.
- **Pending exception:** ExcPend = (ExcCode != 0) & !EXL.
- **Request:** Req = IntPend | ExcPend, combinational. An interrupt has priority over a simultaneous exception.
- **On a clock edge with Req = 1:**
  - EXL is set to 1.
  - Cause.BD is loaded from `BD`.
  - Cause.ExcCode is loaded with 0 if IntPend, otherwise with `ExcCode`.
  - EPC is loaded with `{PC[31:2],2'b00}` if BD = 0, otherwise with PC − 4 (wrapping mod 2^32).
  - Any `mtc0` in the same cycle is discarded.
- **`eret`:** with Req = 0 and EXLClr = 1, EXL is cleared. If `We` writes SR in the same cycle, the write is applied first and EXLClr then forces EXL to 0.
- **IP sampling:** Cause.IP is loaded from `HWInt` on every edge, independent of the mask. HWInt is level-sensitive; the device must deassert the line (for example, by a timer CTRL write) before `eret`.
- **Read path:** DOut is combinational from A1 and current register state. It does not bypass a same-cycle `mtc0`.

## Timing
- Reset low (async): SR = 0, Cause = 0, EPC = 0. Therefore Req = 0, EPC output = 0, and DOut shows 0 for regs 12–14. Reset released mid-handler restarts with EXL = 0 and IE = 0.
- Req is valid in the same cycle as its inputs (zero latency). Register updates take effect on the next rising edge, and Req drops in the following cycle because EXL = 1.
- HWInt to Cause.IP visible: 1 cycle.
- HWInt to Req: 0 cycles when enabled.
- `mtc0` SR enabling a pending interrupt: Req asserts in the cycle after the write edge.
- While EXL = 1, no nested request is raised, whatever HWInt or ExcCode show. Cause.IP keeps tracking HWInt.

## Test plan
1. **Reset and PRId:** reset low for 2 cycles, then read regs 12/13/14/15. Expect 0/0/0/PRID, and Req = 0 with HWInt = 6'h3F.
2. **Timer interrupt:** write SR = 32'h0000_0401, then raise HWInt[0] with PC = 32'h0000_3010 and BD = 0. Expect Req = 1 that cycle. After the edge, expect EPC = 32'h3010, Cause = 32'h0000_0400, SR = 32'h0000_0403, and Req = 0.
3. **Delay-slot exception:** with SR = 1, apply ExcCode = 5'd10, BD = 1, PC = 32'h3024. Expect EPC = 32'h3020 and Cause = 32'h8000_0028.
4. **Priority and masking:**
   - ExcCode = 4 and enabled HWInt[1] in the same cycle: Cause.ExcCode = 0.
   - HWInt[1] with IM[11] = 0: Req stays 0, and Cause.IP shows 6'b000010 after 1 cycle.
5. **Simultaneous events:**
   - `mtc0` EPC = 32'h1234_5677 together with Req: EPC gets PC, and the write is dropped.
   - Later `mtc0` EPC = 32'h1234_5677 alone: reads back 32'h1234_5674.
   - `eret` with SR write 32'h0000_0403 in the same cycle: SR becomes 32'h0000_0401.
6. **Async reset mid-handler:** assert reset between clock edges while EXL = 1. Expect SR/Cause/EPC = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId registers,
// hardware interrupt sampling and the M-stage interrupt/exception request.
module cp0_exception_unit #(
    parameter logic [31:0] PRID = 32'h4D49_5053
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        We,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCode,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPC,
    output logic [31:0] DOut
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        cause_bd;
    logic [5:0]  ip;
    logic [4:0]  exc_code;
    logic [31:0] epc;

    logic int_pend;
    logic exc_pend;
    logic wr_sr;
    logic wr_epc;

    assign int_pend = (|(HWInt & im)) & ie & ~exl;
    assign exc_pend = (ExcCode != 5'd0) & ~exl;
    assign Req      = int_pend | exc_pend;
    assign wr_sr    = We & (A2 == REG_SR);
    assign wr_epc   = We & (A2 == REG_EPC);
    assign EPC      = epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im       <= '0;
            exl      <= 1'b0;
            ie       <= 1'b0;
            cause_bd <= 1'b0;
            ip       <= '0;
            exc_code <= '0;
            epc      <= '0;
        end else begin
            ip <= HWInt;
            if (Req) begin
                // Taking the request drops any same-cycle mtc0.
                exl      <= 1'b1;
                cause_bd <= BD;
                exc_code <= int_pend ? 5'd0 : ExcCode;
                epc      <= BD ? (PC - 32'd4) : {PC[31:2], 2'b00};
            end else begin
                if (wr_sr) begin
                    im  <= DIn[15:10];
                    exl <= DIn[1];
                    ie  <= DIn[0];
                end
                if (wr_epc) begin
                    epc <= {DIn[31:2], 2'b00};
                end
                // eret wins over an SR write landing in the same cycle.
                if (EXLClr) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        DOut = '0;
        case (A1)
            REG_SR:    DOut = {16'h0000, im, 8'h00, exl, ie};
            REG_CAUSE: DOut = {cause_bd, 15'h0000, ip, 3'b000, exc_code, 2'b00};
            REG_EPC:   DOut = epc;
            REG_PRID:  DOut = PRID;
            default:   DOut = '0;
        endcase
    end

endmodule
